// File: rtl/config_pkg.sv
// Shared constants and enums for the configuration loader.
package config_pkg;

  // Configuration register addresses
  localparam logic [31:0] ADDR_MSS      = 32'd0;
  localparam logic [31:0] ADDR_SND_BUF  = 32'd1;
  localparam logic [31:0] ADDR_REV_BUF  = 32'd2;
  localparam logic [31:0] ADDR_FLIGHT   = 32'd3;
  localparam logic [31:0] ADDR_INIT_SEQ = 32'd4;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RESP     = 2'b01,
    ERR_MISMATCH = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA, NEXT, FIN
  } state_e;

endpackage

// File: rtl/config_loader_if.sv
// AXI4-Lite master bundle used by the configuration loader.
interface config_loader_if;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/cfg_phase_timer.sv
// Per-phase cycle counter; flags expiry on the TIMEOUT-th enabled cycle.
module cfg_phase_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over count; saturate at TIMEOUT so the flag stays asserted
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                               cnt_d = '0;
    else if (en_i && cnt_q != W'(TIMEOUT))   cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q >= W'(TIMEOUT - 1));
endmodule

// File: rtl/config_loader.sv
// Writes a snapshot of configuration values over AXI4-Lite, optionally
// reading each one back, and reports the outcome with a done pulse.
module config_loader
  import config_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int TIMEOUT  = 64,
  parameter int VERIFY   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     cfg_mss,
  input  logic [31:0]     cfg_snd_buf,
  input  logic [31:0]     cfg_rev_buf,
  input  logic [31:0]     cfg_flight,
  input  logic [31:0]     cfg_init_seq,
  config_loader_if.master axi,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [2:0]      err_idx
);
  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [4:0][31:0] snap_q;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  err_code_e       err_code_q, err_code_d;
  logic [2:0]      err_idx_q, err_idx_d;
  logic [31:0]     cur_val;
  logic            aw_hs, w_hs, phase_en, tmo;

  assign cur_val = (idx_q < 3'd5) ? snap_q[idx_q] : 32'h0;

  // Address/data track idx and the snapshot, so they cannot move mid-handshake
  assign axi.m_axi_awaddr  = {29'd0, idx_q};
  assign axi.m_axi_awvalid = (state_q == WADDR) && !aw_done_q;
  assign axi.m_axi_wdata   = cur_val;
  assign axi.m_axi_wstrb   = 4'hF;
  assign axi.m_axi_wvalid  = (state_q == WADDR) && !w_done_q;
  assign axi.m_axi_bready  = (state_q == WRESP);
  assign axi.m_axi_araddr  = {29'd0, idx_q};
  assign axi.m_axi_arvalid = (state_q == RADDR);
  assign axi.m_axi_rready  = (state_q == RDATA);

  assign aw_hs    = axi.m_axi_awvalid && axi.m_axi_awready;
  assign w_hs     = axi.m_axi_wvalid && axi.m_axi_wready;
  assign phase_en = (state_q == WADDR) || (state_q == WRESP) ||
                    (state_q == RADDR) || (state_q == RDATA);

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = (err_code_q != ERR_NONE);
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;

  cfg_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_d != state_q),
    .en_i      (phase_en),
    .expired_o (tmo)
  );

  // Sequencer next-state, handshake tracking and error capture
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = WADDR;
        idx_d      = '0;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        err_code_d = ERR_NONE;
        err_idx_d  = '0;
      end
      WADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WRESP;
        else if (tmo) begin
          state_d = FIN; err_code_d = ERR_TIMEOUT; err_idx_d = idx_q;
        end
      end
      WRESP: begin
        if (axi.m_axi_bvalid) begin
          if (axi.m_axi_bresp == RESP_OKAY) state_d = (VERIFY != 0) ? RADDR : NEXT;
          else begin
            state_d = FIN; err_code_d = ERR_RESP; err_idx_d = idx_q;
          end
        end else if (tmo) begin
          state_d = FIN; err_code_d = ERR_TIMEOUT; err_idx_d = idx_q;
        end
      end
      RADDR: begin
        if (axi.m_axi_arready) state_d = RDATA;
        else if (tmo) begin
          state_d = FIN; err_code_d = ERR_TIMEOUT; err_idx_d = idx_q;
        end
      end
      RDATA: begin
        if (axi.m_axi_rvalid) begin
          if (axi.m_axi_rresp != RESP_OKAY) begin
            state_d = FIN; err_code_d = ERR_RESP; err_idx_d = idx_q;
          end else if (axi.m_axi_rdata != cur_val) begin
            state_d = FIN; err_code_d = ERR_MISMATCH; err_idx_d = idx_q;
          end else state_d = NEXT;
        end else if (tmo) begin
          state_d = FIN; err_code_d = ERR_TIMEOUT; err_idx_d = idx_q;
        end
      end
      NEXT: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (idx_q == 3'(NUM_REGS - 1)) state_d = FIN;
        else begin
          idx_d   = idx_q + 3'd1;
          state_d = WADDR;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // Snapshot of the cfg inputs taken when a start is accepted; index = address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snap_q <= '0;
    else if (state_q == IDLE && start)
      snap_q <= {cfg_init_seq, cfg_flight, cfg_rev_buf, cfg_snd_buf, cfg_mss};
  end
endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench: reactive AXI-Lite slave plus an outcome model per run.
module tb_config_loader;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfgv [5];
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [2:0]  err_idx;

  config_loader_if axi();

  config_loader #(.NUM_REGS(5), .TIMEOUT(TO), .VERIFY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_mss(cfgv[0]), .cfg_snd_buf(cfgv[1]), .cfg_rev_buf(cfgv[2]),
    .cfg_flight(cfgv[3]), .cfg_init_seq(cfgv[4]),
    .axi(axi.master),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // slave behaviour knobs (-1 = no fault)
  int aw_delay = 0, w_delay = 0, bad_b_idx = -1, corrupt_idx = -1, stuck_idx = -1;

  // slave state and logs
  int aw_cnt, w_cnt, aw_hi, w_hi, w_hi_peak, bready_rises, done_cnt, stable_viol, wstrb_viol;
  bit aw_seen, w_seen, rpend, prev_bready, aw_pend, w_pend;
  logic [31:0] aw_a, w_d, r_a, aw_prev, w_prev;
  logic [31:0] mem [8];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  int aw_hi_log[$], w_hi_log[$];
  logic cap_err;
  logic [1:0] cap_code;
  logic [2:0] cap_idx;

  initial begin
    axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_bvalid = 0; axi.m_axi_bresp = 0;
    axi.m_axi_arready = 0; axi.m_axi_rvalid = 0; axi.m_axi_rdata = 0; axi.m_axi_rresp = 0;
    done_cnt = 0;
  end

  // Slave acts at the falling edge; a handshake happens at the next rising
  // edge exactly when valid and the ready chosen here are both high.
  always @(negedge clk) begin
    if (!rst_n) begin
      axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_bvalid = 0;
      axi.m_axi_arready = 0; axi.m_axi_rvalid = 0;
      aw_seen = 0; w_seen = 0; rpend = 0; aw_cnt = 0; w_cnt = 0; aw_hi = 0; w_hi = 0;
      aw_pend = 0; w_pend = 0; prev_bready = 0;
    end else begin
      if (aw_pend && !done && (!axi.m_axi_awvalid || axi.m_axi_awaddr !== aw_prev)) stable_viol++;
      if (w_pend && !done && (!axi.m_axi_wvalid || axi.m_axi_wdata !== w_prev)) stable_viol++;
      if (axi.m_axi_awvalid) begin
        aw_hi++;
        axi.m_axi_awready = (aw_cnt >= aw_delay);
        aw_cnt++;
        if (axi.m_axi_awready) begin
          aw_seen = 1; aw_a = axi.m_axi_awaddr; aw_hi_log.push_back(aw_hi); aw_hi = 0;
        end
      end else begin
        axi.m_axi_awready = 0; aw_cnt = 0; aw_hi = 0;
      end
      if (axi.m_axi_wvalid) begin
        w_hi++;
        if (w_hi > w_hi_peak) w_hi_peak = w_hi;
        axi.m_axi_wready = (int'(axi.m_axi_awaddr) != stuck_idx) && (w_cnt >= w_delay);
        w_cnt++;
        if (axi.m_axi_wready) begin
          w_seen = 1; w_d = axi.m_axi_wdata; w_hi_log.push_back(w_hi); w_hi = 0;
          if (axi.m_axi_wstrb !== 4'hF) wstrb_viol++;
        end
      end else begin
        axi.m_axi_wready = 0; w_cnt = 0; w_hi = 0;
      end
      aw_pend = axi.m_axi_awvalid && !axi.m_axi_awready; aw_prev = axi.m_axi_awaddr;
      w_pend  = axi.m_axi_wvalid && !axi.m_axi_wready;   w_prev  = axi.m_axi_wdata;
      if (axi.m_axi_bready && !prev_bready) bready_rises++;
      prev_bready = axi.m_axi_bready;
      axi.m_axi_bvalid = 0;
      if (axi.m_axi_bready && aw_seen && w_seen) begin
        axi.m_axi_bvalid = 1;
        axi.m_axi_bresp = (int'(aw_a) == bad_b_idx) ? 2'b11 : 2'b00;
        wr_addr_q.push_back(aw_a); wr_data_q.push_back(w_d);
        if (axi.m_axi_bresp == 2'b00) mem[aw_a[2:0]] = w_d;
        aw_seen = 0; w_seen = 0;
      end
      axi.m_axi_arready = axi.m_axi_arvalid;
      if (axi.m_axi_arvalid) begin
        rd_addr_q.push_back(axi.m_axi_araddr); rpend = 1; r_a = axi.m_axi_araddr;
      end
      axi.m_axi_rvalid = 0;
      if (axi.m_axi_rready && rpend) begin
        axi.m_axi_rvalid = 1; axi.m_axi_rresp = 2'b00;
        axi.m_axi_rdata = (int'(r_a) == corrupt_idx) ? 32'hFFFF_FFFF : mem[r_a[2:0]];
        rpend = 0;
      end
      if (done) begin
        done_cnt++; cap_err = err; cap_code = err_code; cap_idx = err_idx;
      end
    end
  end

  task automatic set_slave(input int awd, input int wd, input int bb, input int cr, input int st);
    aw_delay = awd; w_delay = wd; bad_b_idx = bb; corrupt_idx = cr; stuck_idx = st;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    aw_hi_log.delete(); w_hi_log.delete();
    bready_rises = 0; stable_viol = 0; wstrb_viol = 0; w_hi_peak = 0;
  endtask

  // Pulse start, optionally scramble inputs afterwards, wait for done.
  task automatic run_seq(input string nm, input int budget, input bit scramble);
    int d0, n;
    d0 = done_cnt;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    if (scramble) for (int i = 0; i < 5; i++) cfgv[i] = $urandom & 32'h7FFF_FFFF;
    n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
    n_cmp++;
    if (done_cnt == d0) begin
      n_bad++; $display("FAIL %s done_within: got none after %0d cycles, need done", nm, budget);
    end
  endtask

  // Outcome model: the first faulty register decides code/index and how far
  // the write/readback traffic got. ftype 0 none,1 bresp,2 rdata,3 wready stuck.
  task automatic check_model(input string nm, input int ftype, input int k, input logic [31:0] sv[5]);
    int ecode, eidx, nw, nr;
    case (ftype)
      1:       begin ecode = 1; eidx = k; nw = k + 1; nr = k;     end
      2:       begin ecode = 2; eidx = k; nw = k + 1; nr = k + 1; end
      3:       begin ecode = 3; eidx = k; nw = k;     nr = k;     end
      default: begin ecode = 0; eidx = 0; nw = 5;     nr = 5;     end
    endcase
    n_cmp++;
    if (cap_err !== (ecode != 0)) begin n_bad++; $display("FAIL %s err: got %b need %b", nm, cap_err, ecode != 0); end
    n_cmp++;
    if (cap_code !== 2'(ecode)) begin n_bad++; $display("FAIL %s err_code: got %0d need %0d", nm, cap_code, ecode); end
    if (ecode != 0) begin
      n_cmp++;
      if (cap_idx !== 3'(eidx)) begin n_bad++; $display("FAIL %s err_idx: got %0d need %0d", nm, cap_idx, eidx); end
    end
    n_cmp++;
    if (wr_addr_q.size() != nw) begin
      n_bad++; $display("FAIL %s write_count: got %0d need %0d", nm, wr_addr_q.size(), nw);
    end else for (int i = 0; i < nw; i++) begin
      n_cmp++;
      if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== sv[i]) begin
        n_bad++; $display("FAIL %s write[%0d]: got %0h=%0h need %0h=%0h", nm, i, wr_addr_q[i], wr_data_q[i], i, sv[i]);
      end
    end
    n_cmp++;
    if (rd_addr_q.size() != nr) begin
      n_bad++; $display("FAIL %s read_count: got %0d need %0d", nm, rd_addr_q.size(), nr);
    end else for (int i = 0; i < nr; i++) begin
      n_cmp++;
      if (rd_addr_q[i] !== 32'(i)) begin n_bad++; $display("FAIL %s read[%0d]: got %0h need %0h", nm, i, rd_addr_q[i], i); end
    end
    n_cmp++;
    if (stable_viol != 0 || wstrb_viol != 0) begin
      n_bad++; $display("FAIL %s protocol: got %0d stability / %0d wstrb violations need 0", nm, stable_viol, wstrb_viol);
    end
  endtask

  task automatic test_reset();
    logic [31:0] agg;
    rst_n = 0;
    #12;
    agg = {busy, done, err, err_code, err_idx, axi.m_axi_awvalid, axi.m_axi_wvalid,
           axi.m_axi_bready, axi.m_axi_arvalid, axi.m_axi_rready};
    n_cmp++;
    if (agg !== 32'd0) begin n_bad++; $display("FAIL reset_ctrl: got %0h need 0", agg); end
    n_cmp++;
    if ({axi.m_axi_awaddr, axi.m_axi_wdata, axi.m_axi_araddr} !== 96'd0) begin
      n_bad++; $display("FAIL reset_addr_data: got %0h/%0h/%0h need 0", axi.m_axi_awaddr, axi.m_axi_wdata, axi.m_axi_araddr);
    end
    @(negedge clk); @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [31:0] sv[5];
    cfgv[0] = 1500; cfgv[1] = 8192; cfgv[2] = 4096; cfgv[3] = 25600; cfgv[4] = 0;
    sv = cfgv;
    set_slave(0, 0, -1, -1, -1);
    run_seq("nominal", 60, 0);
    check_model("nominal", 0, 0, sv);
  endtask

  task automatic test_bresp_err();
    logic [31:0] sv[5];
    cfgv[0] = 9000; sv = cfgv;
    set_slave(0, 0, 0, -1, -1);
    run_seq("bresp_err", 100, 0);
    check_model("bresp_err", 1, 0, sv);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 2'b01 || err_idx !== 3'd0) begin
      n_bad++; $display("FAIL err_hold: got %b/%0d/%0d need 1/1/0", err, err_code, err_idx);
    end
  endtask

  task automatic test_mismatch();
    logic [31:0] sv[5];
    cfgv[0] = 1500; cfgv[1] = 8192; cfgv[2] = 4096; cfgv[3] = 25600; cfgv[4] = 0;
    sv = cfgv;
    set_slave(0, 0, -1, 3, -1);
    run_seq("mismatch", 100, 0);
    check_model("mismatch", 2, 3, sv);
  endtask

  task automatic test_timeout();
    logic [31:0] sv[5];
    for (int i = 0; i < 5; i++) cfgv[i] = $urandom & 32'h7FFF_FFFF;
    sv = cfgv;
    set_slave(0, 0, -1, -1, 2);
    run_seq("timeout", 300, 0);
    check_model("timeout", 3, 2, sv);
    n_cmp++;
    if (w_hi_peak < TO - 1 || w_hi_peak > TO + 1) begin
      n_bad++; $display("FAIL timeout_wvalid_held: got %0d cycles need about %0d", w_hi_peak, TO);
    end
  endtask

  task automatic test_delays(input int awd, input int wd);
    logic [31:0] sv[5];
    string nm;
    nm = $sformatf("delays_%0d_%0d", awd, wd);
    for (int i = 0; i < 5; i++) cfgv[i] = $urandom & 32'h7FFF_FFFF;
    sv = cfgv;
    set_slave(awd, wd, -1, -1, -1);
    run_seq(nm, 300, 0);
    check_model(nm, 0, 0, sv);
    n_cmp++;
    if (bready_rises != 5) begin n_bad++; $display("FAIL %s wresp_entries: got %0d need 5", nm, bready_rises); end
    for (int i = 0; i < aw_hi_log.size() && i < w_hi_log.size(); i++) begin
      n_cmp++;
      if (aw_hi_log[i] != awd + 1 || w_hi_log[i] != wd + 1) begin
        n_bad++; $display("FAIL %s valid_len[%0d]: got aw %0d w %0d need aw %0d w %0d", nm, i, aw_hi_log[i], w_hi_log[i], awd + 1, wd + 1);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] sv[5];
    int d0, n;
    for (int i = 0; i < 5; i++) cfgv[i] = $urandom & 32'h7FFF_FFFF;
    sv = cfgv;
    set_slave(1, 2, -1, -1, -1);
    d0 = done_cnt;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (6) @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    n = 0;
    while (n < 150) begin @(negedge clk); n++; end
    n_cmp++;
    if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL busy_ignore_done: got %0d pulses need 1", done_cnt - d0); end
    check_model("busy_ignore", 0, 0, sv);
  endtask

  task automatic test_reset_mid();
    logic [31:0] sv[5];
    int n, d0;
    for (int i = 0; i < 5; i++) cfgv[i] = $urandom & 32'h7FFF_FFFF;
    set_slave(0, 0, -1, -1, -1);
    d0 = done_cnt;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (!(axi.m_axi_bready && axi.m_axi_awaddr == 32'd1) && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (!(axi.m_axi_bready && axi.m_axi_awaddr == 32'd1)) begin
      n_bad++; $display("FAIL reset_mid_reach_wresp1: got awaddr %0h bready %b need 1/1", axi.m_axi_awaddr, axi.m_axi_bready);
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || axi.m_axi_bready !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_immediate: got busy %b bready %b done %b need 0", busy, axi.m_axi_bready, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0) begin n_bad++; $display("FAIL reset_mid_no_done: got %0d pulses need 0", done_cnt - d0); end
    sv = cfgv;
    set_slave(0, 0, -1, -1, -1);
    run_seq("reset_restart", 100, 0);
    check_model("reset_restart", 0, 0, sv);
  endtask

  task automatic test_random();
    logic [31:0] sv[5];
    int ft, k;
    string nm;
    for (int it = 0; it < 10; it++) begin
      ft = $urandom_range(0, 3);
      k  = $urandom_range(0, 4);
      nm = $sformatf("random_%0d", it);
      for (int i = 0; i < 5; i++) cfgv[i] = $urandom & 32'h7FFF_FFFF;
      sv = cfgv;
      set_slave($urandom_range(0, 3), $urandom_range(0, 3),
                (ft == 1) ? k : -1, (ft == 2) ? k : -1, (ft == 3) ? k : -1);
      run_seq(nm, 400, 1);
      check_model(nm, ft, k, sv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) cfgv[i] = 0;
    for (int i = 0; i < 8; i++) mem[i] = 0;
    test_reset();
    test_nominal();
    test_bresp_err();
    test_mismatch();
    test_timeout();
    test_delays(3, 7);
    test_delays(7, 3);
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter NUM_REGS, default 5: number of configuration registers written, at addresses 0..NUM_REGS-1.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles allowed per handshake phase.
REQ-003 Parameter VERIFY, default 1: when 1, each register is read back after its write and compared.
REQ-004 clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a load sequence.
REQ-007 cfg_mss, cfg_snd_buf, cfg_rev_buf, cfg_flight, cfg_init_seq  in  32 each  values for addresses 0..4.
REQ-008 m_axi_awaddr  out  32; m_axi_awvalid  out  1; m_axi_awready  in  1.
REQ-009 m_axi_wdata  out  32; m_axi_wstrb  out  4; m_axi_wvalid  out  1; m_axi_wready  in  1.
REQ-010 m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
REQ-011 m_axi_araddr  out  32; m_axi_arvalid  out  1; m_axi_arready  in  1.
REQ-012 m_axi_rdata  in  32; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1.
REQ-013 busy  out  1  high from sequence acceptance until done.
REQ-014 done  out  1  one-cycle pulse at sequence end.
REQ-015 err  out  1  valid with done; high if the sequence aborted.
REQ-016 err_code  out  2  00 none, 01 bad bresp/rresp, 10 readback mismatch, 11 timeout.
REQ-017 err_idx  out  3  register index at which the failure occurred.

Function
REQ-018 States SHALL be: IDLE, WADDR, WRESP, RADDR, RDATA, NEXT, FIN.
REQ-019 In IDLE, start=1 SHALL snapshot all cfg_* inputs, clear err/err_code/err_idx, set idx=0 and busy=1, and enter WADDR on the next cycle.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 WADDR SHALL assert awvalid and wvalid together, with awaddr=idx, wdata=snapshot[idx] and wstrb=4'hF.
REQ-022 awvalid and wvalid SHALL each drop independently in the cycle after their own ready is sampled high; the state SHALL move to WRESP only after both handshakes complete, including the case where both complete in the same cycle.
REQ-023 valid SHALL never drop, and addr/data SHALL never change, before the matching ready is sampled.
REQ-024 WRESP SHALL hold bready=1; on bvalid, bresp=00 SHALL go to RADDR (VERIFY=1) or NEXT (VERIFY=0); any other bresp SHALL abort with code 01.
REQ-025 RADDR SHALL assert arvalid with araddr=idx until arready is sampled, then go to RDATA.
REQ-026 RDATA SHALL hold rready=1; on rvalid, rresp!=00 SHALL abort with code 01, rdata!=snapshot[idx] SHALL abort with code 10, and otherwise the state SHALL go to NEXT.
REQ-027 NEXT SHALL go to FIN if idx==NUM_REGS-1, else increment idx and return to WADDR; idx SHALL never wrap.
REQ-028 A phase counter SHALL clear on each state entry and increment each cycle in WADDR/WRESP/RADDR/RDATA; reaching TIMEOUT SHALL abort with code 11.
REQ-029 Abort SHALL record err_code and err_idx=idx, deassert all valid/ready outputs, and go to FIN.
REQ-030 FIN SHALL pulse done=1 for one cycle with err=(err_code!=00), clear busy, and return to IDLE.
REQ-031 err, err_code and err_idx SHALL hold until the next accepted start.
REQ-032 The loader performs no range checking; it writes values as supplied, so out-of-range values surface through bresp.

Reset
REQ-033 rst_n low SHALL immediately force IDLE and drive all valid/ready outputs, busy, done, err, err_code, err_idx, idx and the counter to 0; addr/data outputs SHALL be 0.
REQ-034 Reset mid-transaction SHALL abandon the transaction without emitting done.

Structure
REQ-035 A shared package config_pkg SHALL hold the register address constants (MSS=0, SND_BUF=1, REV_BUF=2, FLIGHT=3, INIT_SEQ=4), the AXI response constants (OKAY=00, SLVERR=10, DECERR=11), the err_code enum and the state enum.
REQ-036 One sub-module, cfg_phase_timer (counter with clear, enable and expiry flag), SHALL implement the timeout.

Verification
REQ-037 Ready-always-high slave, values 1500/8192/4096/25600/0 -> 5 writes, then 5 reads at addrs 0..4; done with err=0 within 60 cycles.
REQ-038 cfg_mss=9000 and slave returns bresp=11 at addr 0 -> done, err=1, err_code=01, err_idx=0, no AR issued.
REQ-039 Slave returns rdata=0xFFFF_FFFF at addr 3 when 25600 was written -> err_code=10, err_idx=3.
REQ-040 wready held low for 64 cycles at idx 2 -> err_code=11, err_idx=2, wvalid held stable until abort.
REQ-041 awready delayed 3 cycles and wready delayed 7 cycles (and the reverse) -> each valid drops individually; WRESP is entered exactly once.
REQ-042 rst_n asserted during WRESP of idx 1, then start -> no done before the restart; the restarted sequence begins at awaddr=0.
